rr_burst_router: RTL and testbench

Downstream data stage of the round-robin interconnect. Consumes the 4-bit one-hot grant of the round-robin arbiter and routes the granted master's burst to the single shared slave channel. Holds the route until the burst ends (last beat or length cap). Drives the arbiter's request vector and masks it while a burst is in flight, so the grant cannot move mid-burst.

---
 rtl/rr_burst_router.sv | 121 ++++++++++++
 tb/tb_rr_burst_router.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/rr_burst_router.sv
// rr_burst_router: routes the granted master's burst onto the shared slave
// channel and holds the route until m_last or the MAX_BURST cap. Request
// vector to the arbiter is masked while a burst is in flight.
module rr_burst_router #(
  parameter int DW        = 8,
  parameter int MAX_BURST = 16
) (
  input  logic          clk,
  input  logic          reset,
  output logic [3:0]    REQ,
  input  logic [3:0]    GNT,
  input  logic [3:0]    m_valid,
  input  logic [4*DW-1:0] m_data,
  input  logic [3:0]    m_last,
  output logic [3:0]    m_ready,
  output logic          s_valid,
  output logic [DW-1:0] s_data,
  output logic          s_last,
  output logic [1:0]    s_src,
  input  logic          s_ready,
  output logic          err_grant,
  output logic          err_cap
);

  localparam int CW = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0] CAP_CNT = CW'(MAX_BURST - 1);

  typedef enum logic {IDLE, XFER} state_t;

  state_t              state, state_nxt;
  logic [1:0]          sel, sel_nxt;
  logic [CW-1:0]       cnt, cnt_nxt;
  logic                err_grant_nxt, err_cap_nxt;
  logic [3:0][DW-1:0]  md;
  logic                gnt_onehot, gnt_multi;
  logic [1:0]          gidx;
  logic                at_cap, burst_end, beat;

  for (genvar i = 0; i < 4; i++) begin : g_unpack
    assign md[i] = m_data[DW*i +: DW];
  end

  // grant decode: zero, one-hot or multi-hot, plus index of the set bit
  assign gnt_multi  = (GNT & (GNT - 4'd1)) != 4'd0;
  assign gnt_onehot = (GNT != 4'd0) && !gnt_multi;
  assign gidx       = GNT[3] ? 2'd3 : GNT[2] ? 2'd2 : GNT[1] ? 2'd1 : 2'd0;

  assign at_cap    = (cnt == CAP_CNT);
  assign burst_end = m_last[sel] | at_cap;
  assign beat      = (state == XFER) && m_valid[sel] && s_ready;

  // state, route select, beat counter and registered error pulses
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      sel       <= 2'd0;
      cnt       <= '0;
      err_grant <= 1'b0;
      err_cap   <= 1'b0;
    end else begin
      state     <= state_nxt;
      sel       <= sel_nxt;
      cnt       <= cnt_nxt;
      err_grant <= err_grant_nxt;
      err_cap   <= err_cap_nxt;
    end
  end

  // next state: latch route on a valid one-hot grant, release on last/cap beat
  always_comb begin
    state_nxt     = state;
    sel_nxt       = sel;
    cnt_nxt       = cnt;
    err_grant_nxt = 1'b0;
    err_cap_nxt   = 1'b0;
    case (state)
      IDLE: begin
        err_grant_nxt = gnt_multi;
        if (gnt_onehot && m_valid[gidx]) begin
          state_nxt = XFER;
          sel_nxt   = gidx;
          cnt_nxt   = '0;
        end
      end
      XFER: begin
        if (beat) begin
          if (burst_end) begin
            state_nxt   = IDLE;
            cnt_nxt     = '0;
            err_cap_nxt = !m_last[sel];
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // outputs: combinational path master->slave; everything forced low in reset
  always_comb begin
    REQ     = 4'b0000;
    m_ready = 4'b0000;
    s_valid = 1'b0;
    s_data  = '0;
    s_last  = 1'b0;
    s_src   = 2'd0;
    if (reset) begin
      s_src = sel;
      if (state == IDLE) begin
        REQ = m_valid;
      end else begin
        s_valid      = m_valid[sel];
        s_data       = md[sel];
        s_last       = burst_end;
        m_ready[sel] = s_ready;
      end
    end
  end

endmodule

// File: tb/tb_rr_burst_router.sv
// tb_rr_burst_router: directed per-cycle vector table for reset, bursts,
// backpressure, bad grant, grant change and reset mid-burst, plus a
// hand-written streaming sequence across the burst cap (MAX_BURST = 4).
module tb_rr_burst_router;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req, gnt, mv, ml, mr;
  logic [31:0] md;
  logic        sv, sl, sr, eg, ec;
  logic [7:0]  sd;
  logic [1:0]  src;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  rr_burst_router #(.DW(8), .MAX_BURST(4)) dut (
    .clk(clk), .reset(rst_n), .REQ(req), .GNT(gnt),
    .m_valid(mv), .m_data(md), .m_last(ml), .m_ready(mr),
    .s_valid(sv), .s_data(sd), .s_last(sl), .s_src(src), .s_ready(sr),
    .err_grant(eg), .err_cap(ec)
  );

  typedef struct {
    string       name;
    logic        rst;
    logic [3:0]  gnt, mv, ml;
    logic [31:0] md;
    logic        sr;
    logic [3:0]  req, mr;
    logic        sv;
    logic [7:0]  sd;
    logic        sl;
    logic [1:0]  src;
    logic        eg, ec;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input string name, input logic rst, input logic [3:0] g,
                     input logic [3:0] v, input logic [3:0] l, input logic [31:0] d,
                     input logic r, input logic [3:0] e_req, input logic [3:0] e_mr,
                     input logic e_sv, input logic [7:0] e_sd, input logic e_sl,
                     input logic [1:0] e_src, input logic e_eg, input logic e_ec);
    vec_t t;
    t.name = name; t.rst = rst; t.gnt = g; t.mv = v; t.ml = l; t.md = d; t.sr = r;
    t.req = e_req; t.mr = e_mr; t.sv = e_sv; t.sd = e_sd; t.sl = e_sl;
    t.src = e_src; t.eg = e_eg; t.ec = e_ec;
    tbl.push_back(t);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic [3:0] g, input logic [3:0] v,
                       input logic [3:0] l, input logic [31:0] d, input logic s);
    rst_n = r; gnt = g; mv = v; ml = l; md = d; sr = s;
  endtask

  initial begin
    // name          rst gnt      mv       ml       data          sr  REQ      m_ready  sv sd     sl src  eg ec
    add("rst0",      0, 4'b0100, 4'b0100, 4'b0000, 32'h55A1_6677, 1, 4'b0000, 4'b0000, 0, 8'h00, 0, 2'd0, 0, 0);
    add("rst1",      0, 4'b0100, 4'b0100, 4'b0000, 32'h55A1_6677, 1, 4'b0000, 4'b0000, 0, 8'h00, 0, 2'd0, 0, 0);
    add("n_idle",    1, 4'b0100, 4'b0100, 4'b0000, 32'h55A1_6677, 1, 4'b0100, 4'b0000, 0, 8'h00, 0, 2'd0, 0, 0);
    add("n_b1",      1, 4'b0100, 4'b0100, 4'b0000, 32'h55A1_6677, 1, 4'b0000, 4'b0100, 1, 8'hA1, 0, 2'd2, 0, 0);
    add("n_b2",      1, 4'b0100, 4'b0100, 4'b0000, 32'h55A2_6677, 1, 4'b0000, 4'b0100, 1, 8'hA2, 0, 2'd2, 0, 0);
    add("n_b3",      1, 4'b0100, 4'b0100, 4'b0100, 32'h55A3_6677, 1, 4'b0000, 4'b0100, 1, 8'hA3, 1, 2'd2, 0, 0);
    add("n_gap",     1, 4'b0000, 4'b0100, 4'b0000, 32'h55A1_6677, 1, 4'b0100, 4'b0000, 0, 8'h00, 0, 2'd2, 0, 0);
    add("bp_idle",   1, 4'b0100, 4'b0100, 4'b0000, 32'h55A1_6677, 1, 4'b0100, 4'b0000, 0, 8'h00, 0, 2'd2, 0, 0);
    add("bp_b1",     1, 4'b0100, 4'b0100, 4'b0000, 32'h55A1_6677, 1, 4'b0000, 4'b0100, 1, 8'hA1, 0, 2'd2, 0, 0);
    add("bp_w1",     1, 4'b0100, 4'b0100, 4'b0000, 32'h55A2_6677, 0, 4'b0000, 4'b0000, 1, 8'hA2, 0, 2'd2, 0, 0);
    add("bp_w2",     1, 4'b0100, 4'b0100, 4'b0000, 32'h55A2_6677, 0, 4'b0000, 4'b0000, 1, 8'hA2, 0, 2'd2, 0, 0);
    add("bp_b2",     1, 4'b0100, 4'b0100, 4'b0000, 32'h55A2_6677, 1, 4'b0000, 4'b0100, 1, 8'hA2, 0, 2'd2, 0, 0);
    add("bp_b3",     1, 4'b0100, 4'b0100, 4'b0100, 32'h55A3_6677, 1, 4'b0000, 4'b0100, 1, 8'hA3, 1, 2'd2, 0, 0);
    add("bp_gap",    1, 4'b0000, 4'b0000, 4'b0000, 32'h0000_0000, 1, 4'b0000, 4'b0000, 0, 8'h00, 0, 2'd2, 0, 0);
    add("bg_multi",  1, 4'b0011, 4'b0011, 4'b0000, 32'h0000_2010, 1, 4'b0011, 4'b0000, 0, 8'h00, 0, 2'd2, 0, 0);
    add("bg_pulse",  1, 4'b0000, 4'b0011, 4'b0000, 32'h0000_2010, 1, 4'b0011, 4'b0000, 0, 8'h00, 0, 2'd2, 1, 0);
    add("bg_clear",  1, 4'b0000, 4'b0011, 4'b0000, 32'h0000_2010, 1, 4'b0011, 4'b0000, 0, 8'h00, 0, 2'd2, 0, 0);
    add("gc_idle",   1, 4'b0001, 4'b1001, 4'b0000, 32'hC100_00B1, 1, 4'b1001, 4'b0000, 0, 8'h00, 0, 2'd2, 0, 0);
    add("gc_b1",     1, 4'b1000, 4'b1001, 4'b0000, 32'hC100_00B1, 1, 4'b0000, 4'b0001, 1, 8'hB1, 0, 2'd0, 0, 0);
    add("gc_b2",     1, 4'b1000, 4'b1001, 4'b0000, 32'hC100_00B2, 1, 4'b0000, 4'b0001, 1, 8'hB2, 0, 2'd0, 0, 0);
    add("gc_b3",     1, 4'b1000, 4'b1001, 4'b0001, 32'hC100_00B3, 1, 4'b0000, 4'b0001, 1, 8'hB3, 1, 2'd0, 0, 0);
    add("gc_gap",    1, 4'b1000, 4'b1000, 4'b1000, 32'hC100_0000, 1, 4'b1000, 4'b0000, 0, 8'h00, 0, 2'd0, 0, 0);
    add("gc_m3",     1, 4'b0000, 4'b1000, 4'b1000, 32'hC100_0000, 1, 4'b0000, 4'b1000, 1, 8'hC1, 1, 2'd3, 0, 0);
    add("nv_grant",  1, 4'b0010, 4'b0000, 4'b0000, 32'h0000_0000, 1, 4'b0000, 4'b0000, 0, 8'h00, 0, 2'd3, 0, 0);
    add("nv_stay",   1, 4'b0000, 4'b0000, 4'b0000, 32'h0000_0000, 1, 4'b0000, 4'b0000, 0, 8'h00, 0, 2'd3, 0, 0);
    add("rm_idle",   1, 4'b0010, 4'b0010, 4'b0000, 32'h7700_D1EE, 1, 4'b0010, 4'b0000, 0, 8'h00, 0, 2'd3, 0, 0);
    add("rm_b1",     1, 4'b0000, 4'b0010, 4'b0000, 32'h7700_D1EE, 1, 4'b0000, 4'b0010, 1, 8'hD1, 0, 2'd1, 0, 0);
    add("rm_b2",     1, 4'b0000, 4'b0010, 4'b0000, 32'h7700_D2EE, 1, 4'b0000, 4'b0010, 1, 8'hD2, 0, 2'd1, 0, 0);
    add("rm_rst",    0, 4'b0010, 4'b0010, 4'b0000, 32'h7700_D3EE, 1, 4'b0000, 4'b0000, 0, 8'h00, 0, 2'd0, 0, 0);
    add("rm_idle2",  1, 4'b0000, 4'b0010, 4'b0000, 32'h7700_D3EE, 1, 4'b0010, 4'b0000, 0, 8'h00, 0, 2'd0, 0, 0);
    add("rm_regnt",  1, 4'b0010, 4'b0010, 4'b0000, 32'h7700_D3EE, 1, 4'b0010, 4'b0000, 0, 8'h00, 0, 2'd0, 0, 0);
    add("rm_b3",     1, 4'b0000, 4'b0010, 4'b0010, 32'h7700_D3EE, 1, 4'b0000, 4'b0010, 1, 8'hD3, 1, 2'd1, 0, 0);
    add("rm_gap",    1, 4'b0000, 4'b0000, 4'b0000, 32'h0000_0000, 1, 4'b0000, 4'b0000, 0, 8'h00, 0, 2'd1, 0, 0);

    // one unchecked reset edge so the error registers hold a known value
    drive(1'b0, 4'b0000, 4'b0000, 4'b0000, 32'h0, 1'b1);
    @(posedge clk); #1;

    foreach (tbl[i]) begin
      drive(tbl[i].rst, tbl[i].gnt, tbl[i].mv, tbl[i].ml, tbl[i].md, tbl[i].sr);
      #2;
      chk({tbl[i].name, ".REQ"},       32'(req), 32'(tbl[i].req));
      chk({tbl[i].name, ".m_ready"},   32'(mr),  32'(tbl[i].mr));
      chk({tbl[i].name, ".s_valid"},   32'(sv),  32'(tbl[i].sv));
      chk({tbl[i].name, ".s_src"},     32'(src), 32'(tbl[i].src));
      chk({tbl[i].name, ".err_grant"}, 32'(eg),  32'(tbl[i].eg));
      chk({tbl[i].name, ".err_cap"},   32'(ec),  32'(tbl[i].ec));
      if (tbl[i].sv || !tbl[i].rst) begin
        chk({tbl[i].name, ".s_data"}, 32'(sd), 32'(tbl[i].sd));
        chk({tbl[i].name, ".s_last"}, 32'(sl), 32'(tbl[i].sl));
      end
      @(posedge clk); #1;
    end

    // master 1 streams F1..F6 with m_last on F6; cap of 4 splits it 4 + 2
    begin
      int  sent    = 0;
      int  nb      = 0;
      int  pulses  = 0;
      int  budget  = 40;
      bit  busy    = 0;
      bit  ec_pend = 0;
      bit  exp_last;
      while (sent < 6 && budget > 0) begin
        drive(1'b1, busy ? 4'b0000 : 4'b0010, 4'b0010,
              (sent == 5) ? 4'b0010 : 4'b0000,
              {8'h00, 8'h00, 8'(8'hF1 + sent), 8'h99}, 1'b1);
        #2;
        exp_last = (nb == 3) || (sent == 5);
        chk("cap.err_cap", 32'(ec), 32'(ec_pend));
        if (ec) pulses++;
        if (!busy) begin
          chk("cap.idle_s_valid", 32'(sv),  32'd0);
          chk("cap.idle_REQ",     32'(req), 32'b0010);
          busy    = 1;
          nb      = 0;
          ec_pend = 0;
        end else begin
          chk("cap.s_valid", 32'(sv),  32'd1);
          chk("cap.s_data",  32'(sd),  32'(8'hF1 + sent));
          chk("cap.s_last",  32'(sl),  32'(exp_last));
          chk("cap.s_src",   32'(src), 32'd1);
          ec_pend = exp_last && (sent != 5);
          sent++;
          nb++;
          if (exp_last) busy = 0;
        end
        @(posedge clk); #1;
        budget--;
      end
      chk("cap.timeout_beats_sent", 32'(sent), 32'd6);
      drive(1'b1, 4'b0000, 4'b0000, 4'b0000, 32'h0, 1'b1);
      #2;
      chk("cap.end_err_cap", 32'(ec), 32'(ec_pend));
      if (ec) pulses++;
      chk("cap.end_s_valid", 32'(sv), 32'd0);
      chk("cap.err_cap_pulses", 32'(pulses), 32'd1);
      @(posedge clk); #1;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
